sr_mc_dispatch: RTL and testbench

//  Dispatches multi-cycle instructions from the schoolRISCV core to up to N_UNITS coprocessor units.

---
 rtl/sr_mc_dispatch_pkg.sv | 18 +
 rtl/sr_mc_watchdog.sv | 32 +++
 rtl/sr_mc_dispatch.sv | 156 +++++++++++++++
 tb/tb_sr_mc_dispatch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_mc_dispatch_pkg.sv
// Shared types for the multi-cycle dispatch block: FSM state encodings and
// the watchdog counter sizing helper.
package sr_mc_dispatch_pkg;

    typedef enum logic [1:0] {
        MC_ST_IDLE   = 2'd0,
        MC_ST_LAUNCH = 2'd1,
        MC_ST_WAIT   = 2'd2,
        MC_ST_WB     = 2'd3
    } mc_state_t;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so the
    // port widths never collapse to zero.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sr_mc_watchdog.sv
// Wait-cycle counter: cleared on launch, counts while enabled, flags the
// cycle whose incremented count reaches TIMEOUT. TIMEOUT=0 never expires.
module sr_mc_watchdog
    import sr_mc_dispatch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = wd_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the number of completed wait cycles, so this cycle is
    // number r_cnt+1.
    assign o_expired = (TIMEOUT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/sr_mc_dispatch.sv
// Dispatches multi-cycle ops to started/busy coprocessor units, stalls the
// PC while a unit runs and performs a single register-file write-back.
module sr_mc_dispatch
    import sr_mc_dispatch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int N_UNITS = 4,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_i,
    input  logic [SEL_W-1:0]        unit_sel_i,
    input  logic [4:0]              rd_i,
    input  logic [XLEN-1:0]         srcA_i,
    input  logic [XLEN-1:0]         srcB_i,
    output logic                    stall_o,
    output logic [N_UNITS-1:0]      unit_start_o,
    output logic [XLEN-1:0]         unit_a_o,
    output logic [XLEN-1:0]         unit_b_o,
    input  logic [N_UNITS-1:0]      unit_busy_i,
    input  logic [N_UNITS*XLEN-1:0] unit_result_i,
    output logic                    wb_we_o,
    output logic [4:0]              wb_addr_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic                    err_o
);

    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_UNITS);

    mc_state_t        r_state;
    logic [SEL_W-1:0] r_sel;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_res;
    logic             r_settle;

    logic             w_sel_ok;
    logic             w_busy_sel;
    logic [XLEN-1:0]  w_res_sel;
    logic             w_expired;
    logic             w_done;
    logic             w_timeout;

    assign w_sel_ok = ({1'b0, unit_sel_i} < N_LIM);

    always_comb begin
        w_busy_sel = 1'b0;
        w_res_sel  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_busy_sel = unit_busy_i[k];
                w_res_sel  = unit_result_i[k*XLEN +: XLEN];
            end
        end
    end

    sr_mc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == MC_ST_LAUNCH),
        .i_en      (r_state == MC_ST_WAIT),
        .o_expired (w_expired)
    );

    // The first wait cycle is the unit's settle time: busy is not yet valid.
    assign w_done    = (r_state == MC_ST_WAIT) && !r_settle && !w_busy_sel;
    assign w_timeout = w_expired && !w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MC_ST_IDLE;
            r_sel    <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_settle <= 1'b0;
        end else begin
            case (r_state)
                MC_ST_IDLE: begin
                    if (issue_i && w_sel_ok) begin
                        r_sel   <= unit_sel_i;
                        r_rd    <= rd_i;
                        r_a     <= srcA_i;
                        r_b     <= srcB_i;
                        r_state <= MC_ST_LAUNCH;
                    end
                end
                MC_ST_LAUNCH: begin
                    r_settle <= 1'b1;
                    r_state  <= MC_ST_WAIT;
                end
                MC_ST_WAIT: begin
                    r_settle <= 1'b0;
                    if (w_done) begin
                        r_res   <= w_res_sel;
                        r_state <= MC_ST_WB;
                    end else if (w_timeout) begin
                        r_state <= MC_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= MC_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_o   = 1'b0;
        err_o     = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_data_o = '0;
        unit_a_o  = '0;
        unit_b_o  = '0;
        case (r_state)
            MC_ST_IDLE: begin
                stall_o = issue_i && w_sel_ok;
                err_o   = issue_i && !w_sel_ok;
            end
            MC_ST_LAUNCH: begin
                stall_o  = 1'b1;
                unit_a_o = r_a;
                unit_b_o = r_b;
            end
            MC_ST_WAIT: begin
                stall_o  = !w_timeout;
                err_o    = w_timeout;
                unit_a_o = r_a;
                unit_b_o = r_b;
            end
            default: begin
                // Write-back cycle: the PC advances on this edge.
                wb_we_o   = (r_rd != 5'd0);
                wb_addr_o = r_rd;
                wb_data_o = r_res;
                unit_a_o  = r_a;
                unit_b_o  = r_b;
            end
        endcase
    end

    always_comb begin
        unit_start_o = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            unit_start_o[k] = (r_state == MC_ST_LAUNCH) && (r_sel == SEL_W'(k));
        end
    end

endmodule

// File: tb/tb_sr_mc_dispatch.sv
// Randomized bench for sr_mc_dispatch against a cycle-trace model of one
// multi-cycle op; unit models keep busy high for a chosen number of cycles.
module tb_sr_mc_dispatch;

    localparam int XLEN = 32;
    localparam int N    = 4;
    localparam int SW   = 3;
    localparam int TO   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_i;
    logic [SW-1:0]     unit_sel_i;
    logic [4:0]        rd_i;
    logic [XLEN-1:0]   srcA_i;
    logic [XLEN-1:0]   srcB_i;
    logic              stall_o;
    logic [N-1:0]      unit_start_o;
    logic [XLEN-1:0]   unit_a_o;
    logic [XLEN-1:0]   unit_b_o;
    logic [N-1:0]      unit_busy_i;
    logic [N*XLEN-1:0] unit_result_i;
    logic              wb_we_o;
    logic [4:0]        wb_addr_o;
    logic [XLEN-1:0]   wb_data_o;
    logic              err_o;

    int passed = 0;
    int total  = 0;

    int                cur_sel = -1;
    int                dur     = 1;
    int                rem     = 0;
    logic              stuck   = 1'b0;
    logic [XLEN-1:0]   cur_res = '0;
    logic [N-1:0]      noise_busy = '0;
    logic [N*XLEN-1:0] noise_res  = '0;

    always #5 clk = ~clk;

    sr_mc_dispatch #(
        .XLEN    (XLEN),
        .N_UNITS (N),
        .SEL_W   (SW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_i       (issue_i),
        .unit_sel_i    (unit_sel_i),
        .rd_i          (rd_i),
        .srcA_i        (srcA_i),
        .srcB_i        (srcB_i),
        .stall_o       (stall_o),
        .unit_start_o  (unit_start_o),
        .unit_a_o      (unit_a_o),
        .unit_b_o      (unit_b_o),
        .unit_busy_i   (unit_busy_i),
        .unit_result_i (unit_result_i),
        .wb_we_o       (wb_we_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .err_o         (err_o)
    );

    // Selected unit: busy for 'dur' cycles after the cycle its start is seen.
    always @(posedge clk) begin
        if (|unit_start_o) rem <= dur;
        else if (rem > 0)  rem <= rem - 1;
    end

    // Unselected units carry random busy/result noise that must be ignored.
    always_comb begin
        unit_busy_i   = noise_busy;
        unit_result_i = noise_res;
        if (cur_sel >= 0 && cur_sel < N) begin
            unit_busy_i[cur_sel]                  = stuck || (rem != 0);
            unit_result_i[cur_sel*XLEN +: XLEN]   = cur_res;
        end
    end

    task automatic shake_noise();
        noise_busy = N'($urandom);
        noise_res  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive_junk();
        issue_i    = 1'($urandom);
        unit_sel_i = SW'($urandom);
        rd_i       = 5'($urandom);
        srcA_i     = $urandom;
        srcB_i     = $urandom;
    endtask

    // Whole-op trace: every output compared every cycle from issue to the
    // final (write-back or abort) cycle.
    task automatic run_op(input int sel, input logic [4:0] rd, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int bcy, input logic stk,
                          input logic [XLEN-1:0] res, input string nm);
        logic       valid;
        logic       done;
        int         len;
        logic [107:0] exp_v;
        logic [107:0] got_v;
        logic       e_stall, e_err, e_we;
        logic [N-1:0] e_start;
        logic [4:0] e_addr;
        logic [XLEN-1:0] e_data, e_a, e_b;
        valid = (sel < N);
        done  = valid && !stk && (bcy + 1 <= TO);
        if (!valid)    len = 1;
        else if (done) len = bcy + 4;
        else           len = TO + 2;
        cur_sel = valid ? sel : -1;
        dur     = bcy;
        stuck   = stk;
        cur_res = res;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                issue_i    = 1'b1;
                unit_sel_i = SW'(sel);
                rd_i       = rd;
                srcA_i     = a;
                srcB_i     = b;
            end else begin
                drive_junk();
            end
            shake_noise();
            @(negedge clk);
            e_stall = valid && (done ? (c <= bcy + 3) : (c <= TO + 1));
            e_err   = !valid ? (c == 1) : (!done && c == len);
            e_start = (valid && c == 2) ? N'(1 << sel) : '0;
            e_we    = done && (c == len) && (rd != 5'd0);
            e_addr  = (done && c == len) ? rd : 5'd0;
            e_data  = (done && c == len) ? res : '0;
            e_a     = (valid && c >= 2) ? a : '0;
            e_b     = (valid && c >= 2) ? b : '0;
            exp_v = {e_stall, e_err, e_start, e_we, e_addr, e_data, e_a, e_b};
            got_v = {stall_o, err_o, unit_start_o, wb_we_o, wb_addr_o, wb_data_o, unit_a_o, unit_b_o};
            total++;
            if (got_v !== exp_v)
                $display("FAIL %s cycle %0d {stall,err,start,we,addr,data,a,b} got %h want %h",
                         nm, c, got_v, exp_v);
            else
                passed++;
        end
    endtask

    task automatic idle_cycles(input int n, input string nm);
        logic [107:0] got_v;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            drive_junk();
            issue_i = 1'b0;
            shake_noise();
            @(negedge clk);
            got_v = {stall_o, err_o, unit_start_o, wb_we_o, wb_addr_o, wb_data_o, unit_a_o, unit_b_o};
            total++;
            if (got_v !== '0)
                $display("FAIL %s idle %0d outputs got %h want 0", nm, c, got_v);
            else
                passed++;
        end
    endtask

    task automatic test_reset();
        logic [107:0] got_v;
        rst = 1'b1;
        issue_i = 1'b0; unit_sel_i = '0; rd_i = '0; srcA_i = '0; srcB_i = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            shake_noise();
            @(negedge clk);
            got_v = {stall_o, err_o, unit_start_o, wb_we_o, wb_addr_o, wb_data_o, unit_a_o, unit_b_o};
            total++;
            if (got_v !== '0) $display("FAIL reset cycle %0d outputs got %h want 0", c, got_v);
            else passed++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2, "post_reset");
    endtask

    task automatic test_unit0();
        run_op(0, 5'd5, 32'hA5A5_0001, 32'h0000_0077, 5, 1'b0, 32'h0001_2345, "unit0_b5");
        idle_cycles(1, "unit0_after");
    endtask

    task automatic test_rd0();
        run_op(3, 5'd0, $urandom, $urandom, 3, 1'b0, 32'hDEAD_BEEF, "unit3_rd0");
        idle_cycles(1, "rd0_after");
    endtask

    task automatic test_bad_sel();
        run_op(5, 5'd9, $urandom, $urandom, 2, 1'b0, $urandom, "sel5");
        idle_cycles(2, "sel5_after");
        run_op(4, 5'd9, $urandom, $urandom, 2, 1'b0, $urandom, "sel4");
    endtask

    task automatic test_timeout();
        run_op(1, 5'd12, $urandom, $urandom, 60, 1'b1, $urandom, "timeout");
        run_op(2, 5'd13, $urandom, $urandom, 2, 1'b0, 32'h1357_9BDF, "after_timeout");
        run_op(1, 5'd14, $urandom, $urandom, 9, 1'b0, 32'h2468_ACE0, "done_at_limit");
        run_op(1, 5'd15, $urandom, $urandom, 10, 1'b0, $urandom, "just_over_limit");
        run_op(0, 5'd16, $urandom, $urandom, 1, 1'b0, 32'h0000_0F0F, "busy_1");
    endtask

    task automatic test_reset_mid();
        logic [107:0] got_v;
        cur_sel = 2; dur = 8; stuck = 1'b0; cur_res = 32'hCAFE_F00D;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                issue_i = 1'b1; unit_sel_i = 3'd2; rd_i = 5'd7;
                srcA_i = $urandom; srcB_i = $urandom;
            end else begin
                issue_i = 1'b0;
            end
            if (c == 5) rst = 1'b1;
            shake_noise();
            @(negedge clk);
            total++;
            if (stall_o !== 1'b1) $display("FAIL reset_mid cycle %0d stall_o got %b want 1", c, stall_o);
            else passed++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        shake_noise();
        @(negedge clk);
        got_v = {stall_o, err_o, unit_start_o, wb_we_o, wb_addr_o, wb_data_o, unit_a_o, unit_b_o};
        total++;
        if (got_v !== '0) $display("FAIL reset_mid after_rst outputs got %h want 0", got_v);
        else passed++;
        idle_cycles(12, "reset_mid_tail");
    endtask

    task automatic test_back_to_back();
        run_op(1, 5'd3, 32'h1111_1111, 32'h2222_2222, 2, 1'b0, 32'hAAAA_0001, "b2b_first");
        run_op(2, 5'd4, 32'h3333_3333, 32'h4444_4444, 4, 1'b0, 32'hBBBB_0002, "b2b_second");
        idle_cycles(1, "b2b_after");
    endtask

    task automatic test_random();
        int sel, bcy, gap;
        logic stk;
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 5);
            stk = ($urandom_range(0, 7) == 0);
            bcy = stk ? 40 : $urandom_range(1, 11);
            run_op(sel, 5'($urandom), $urandom, $urandom, bcy, stk, $urandom, "random");
            gap = $urandom_range(0, 2);
            if (gap > 0) idle_cycles(gap, "random_gap");
        end
    endtask

    initial begin
        rst = 1'b1;
        issue_i = 1'b0; unit_sel_i = '0; rd_i = '0; srcA_i = '0; srcB_i = '0;
        test_reset();
        test_unit0();
        test_rd0();
        test_bad_sel();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
